// File: rtl/rcpu_irq_ctrl_if.sv
// Register-port and single-interrupt signals between the interrupt controller and the RCPU core/bus.
// The slave modport is the controller's view; master is the core/bus side.
interface rcpu_irq_ctrl_if #(
  parameter int M = 16,
  parameter int N = 32
);
  logic         regWE;
  logic [2:0]   regAddr;
  logic [M-1:0] regWData;
  logic [M-1:0] regRData;
  logic         irq;
  logic [N-1:0] intAddr;
  logic [M-1:0] intData;
  logic         turnOffIRQ;

  modport master (
    output regWE, regAddr, regWData, turnOffIRQ,
    input  regRData, irq, intAddr, intData
  );

  modport slave (
    input  regWE, regAddr, regWData, turnOffIRQ,
    output regRData, irq, intAddr, intData
  );
endinterface

// File: rtl/rcpu_irq_ctrl.sv
// Multi-channel interrupt controller for the RCPU single-interrupt interface:
// edge/level capture, masking, lowest-index priority and vector address generation.
module rcpu_irq_ctrl #(
  parameter int CHANNELS     = 8,
  parameter int M            = 16,
  parameter int N            = 32,
  parameter int VECTOR_SHIFT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] req,
  rcpu_irq_ctrl_if.slave      bus
);

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_MASK    = 3'd1;
  localparam logic [2:0] REG_MODE    = 3'd2;
  localparam logic [2:0] REG_PENDING = 3'd3;
  localparam logic [2:0] REG_BASE_HI = 3'd4;
  localparam logic [2:0] REG_BASE_LO = 3'd5;
  localparam logic [2:0] REG_STATUS  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t              state_r;
  logic                ctrl_en_r;
  logic [CHANNELS-1:0] mask_r;
  logic [CHANNELS-1:0] mode_r;
  logic [CHANNELS-1:0] pending_r;
  logic [CHANNELS-1:0] prev_req_r;
  logic [M-1:0]        base_hi_r;
  logic [M-1:0]        base_lo_r;
  logic [3:0]          active_r;
  logic                irq_r;
  logic [N-1:0]        int_addr_r;
  logic [M-1:0]        int_data_r;

  logic [CHANNELS-1:0] edge_s;
  logic [CHANNELS-1:0] w1c_s;
  logic [CHANNELS-1:0] ack_clr_s;
  logic [CHANNELS-1:0] pending_next_s;
  logic [CHANNELS-1:0] eligible_s;
  logic [3:0]          winner_s;
  logic [N-1:0]        base_s;
  logic [N-1:0]        vec_addr_s;
  logic [M-1:0]        status_s;
  logic [M-1:0]        rdata_s;

  assign edge_s     = req & ~prev_req_r;
  assign base_s     = N'({base_hi_r, base_lo_r});
  assign vec_addr_s = base_s + (N'(winner_s) << VECTOR_SHIFT);

  // Clear sources for edge-mode pending bits: software write-1-clear and core acknowledge
  always_comb begin
    w1c_s     = '0;
    ack_clr_s = '0;
    if (bus.regWE && (bus.regAddr == REG_PENDING)) begin
      w1c_s = bus.regWData[CHANNELS-1:0];
    end else begin
      w1c_s = '0;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      ack_clr_s[i] = (state_r == ST_ASSERT) && bus.turnOffIRQ && (active_r == 4'(i));
    end
  end

  // Next pending: a new edge always wins over a same-cycle clear; level bits track req
  always_comb begin
    pending_next_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (mode_r[i]) begin
        pending_next_s[i] = (pending_r[i] & ~w1c_s[i] & ~ack_clr_s[i]) | edge_s[i];
      end else begin
        pending_next_s[i] = req[i];
      end
    end
  end

  // Eligible set and lowest-index winner
  always_comb begin
    eligible_s = '0;
    winner_s   = 4'd0;
    if (ctrl_en_r) begin
      eligible_s = pending_r & mask_r;
    end else begin
      eligible_s = '0;
    end
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (eligible_s[i]) begin
        winner_s = 4'(i);
      end else begin
        winner_s = winner_s;
      end
    end
  end

  // Register read mux, combinational from regAddr
  always_comb begin
    status_s     = '0;
    status_s[15] = (state_r != ST_IDLE);
    status_s[3:0] = active_r;
    rdata_s      = '0;
    case (bus.regAddr)
      REG_CTRL:    rdata_s = M'(ctrl_en_r);
      REG_MASK:    rdata_s = M'(mask_r);
      REG_MODE:    rdata_s = M'(mode_r);
      REG_PENDING: rdata_s = M'(pending_r);
      REG_BASE_HI: rdata_s = base_hi_r;
      REG_BASE_LO: rdata_s = base_lo_r;
      REG_STATUS:  rdata_s = status_s;
      default:     rdata_s = '0;
    endcase
  end

  // Software-visible configuration registers and request capture
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_en_r  <= 1'b0;
      mask_r     <= '0;
      mode_r     <= '1;
      base_hi_r  <= '0;
      base_lo_r  <= '0;
      pending_r  <= '0;
      prev_req_r <= '0;
    end else begin
      pending_r  <= pending_next_s;
      prev_req_r <= req;
      if (bus.regWE) begin
        case (bus.regAddr)
          REG_CTRL:    ctrl_en_r <= bus.regWData[0];
          REG_MASK:    mask_r    <= bus.regWData[CHANNELS-1:0];
          REG_MODE:    mode_r    <= bus.regWData[CHANNELS-1:0];
          REG_BASE_HI: base_hi_r <= bus.regWData;
          REG_BASE_LO: base_lo_r <= bus.regWData;
          default:     ;
        endcase
      end
    end
  end

  // Delivery FSM; outputs are registered alongside the state so they are glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      active_r   <= 4'd0;
      irq_r      <= 1'b0;
      int_addr_r <= '0;
      int_data_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|eligible_s) begin
            state_r    <= ST_ASSERT;
            active_r   <= winner_s;
            irq_r      <= 1'b1;
            int_addr_r <= vec_addr_s;
            int_data_r <= M'(winner_s);
          end
        end
        ST_ASSERT: begin
          if (bus.turnOffIRQ) begin
            state_r    <= ST_HOLDOFF;
            irq_r      <= 1'b0;
            int_addr_r <= '0;
            int_data_r <= '0;
          end
        end
        ST_HOLDOFF: state_r <= ST_IDLE;
        default: begin
          state_r    <= ST_IDLE;
          irq_r      <= 1'b0;
          int_addr_r <= '0;
          int_data_r <= '0;
        end
      endcase
    end
  end

  assign bus.regRData = rdata_s;
  assign bus.irq      = irq_r;
  assign bus.intAddr  = int_addr_r;
  assign bus.intData  = int_data_r;

endmodule

// File: tb/tb_rcpu_irq_ctrl.sv
// Randomised scoreboard bench for rcpu_irq_ctrl against a transaction-level reference model.
module tb_rcpu_irq_ctrl;

  localparam int CH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] req = '0;

  rcpu_irq_ctrl_if #(.M(16), .N(32)) bus ();

  rcpu_irq_ctrl #(.CHANNELS(CH), .M(16), .N(32), .VECTOR_SHIFT(2)) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        cyc;
    int        chan;
    bit [31:0] addr;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   mon_en  = 1'b0;
  bit   prev_irq = 1'b0;

  // Reference model state: which channel is being presented (-1 = none) and quiet cycles left
  bit [CH-1:0] m_pend, m_prev, m_mask, m_mode;
  bit          m_ctrl;
  bit [31:0]   m_base;
  int          m_serving;
  int          m_cool;
  int          m_active;
  bit [31:0]   m_addr;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_pend = '0; m_prev = '0; m_mask = '0; m_mode = '1; m_ctrl = 1'b0;
    m_base = 32'h0; m_serving = -1; m_cool = 0; m_active = 0; m_addr = 32'h0;
  endfunction

  function automatic bit [15:0] m_reg(bit [2:0] a);
    case (a)
      3'd0: return 16'(m_ctrl);
      3'd1: return 16'(m_mask);
      3'd2: return 16'(m_mode);
      3'd3: return 16'(m_pend);
      3'd4: return m_base[31:16];
      3'd5: return m_base[15:0];
      3'd6: return (((m_serving >= 0) || (m_cool > 0)) ? 16'h8000 : 16'h0000) | 16'(m_active);
      default: return 16'h0000;
    endcase
  endfunction

  // Advances the model by one clock using the inputs present before the edge
  function automatic void model_step();
    bit [CH-1:0] elig, clr, rise, wc;
    if (rst) begin
      model_reset();
      return;
    end
    elig = m_ctrl ? (m_pend & m_mask) : '0;
    clr  = '0;
    if (m_serving >= 0) begin
      if (bus.turnOffIRQ) begin
        clr = CH'(1 << m_serving);
        m_serving = -1;
        m_cool = 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (elig != 0) begin
      for (int i = CH - 1; i >= 0; i--) if (elig[i]) m_serving = i;
      m_active = m_serving;
      m_addr = m_base + (32'(m_serving) * 32'd4);
      sb_q.push_back('{cyc, m_serving, m_addr});
    end
    rise = req & ~m_prev;
    wc = (bus.regWE && bus.regAddr == 3'd3) ? bus.regWData[CH-1:0] : '0;
    for (int i = 0; i < CH; i++)
      m_pend[i] = m_mode[i] ? ((m_pend[i] && !clr[i] && !wc[i]) || rise[i]) : req[i];
    if (bus.regWE) begin
      case (bus.regAddr)
        3'd0: m_ctrl = bus.regWData[0];
        3'd1: m_mask = bus.regWData[CH-1:0];
        3'd2: m_mode = bus.regWData[CH-1:0];
        3'd4: m_base[31:16] = bus.regWData;
        3'd5: m_base[15:0] = bus.regWData;
        default: ;
      endcase
    end
    m_prev = req;
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic wr(bit [2:0] a, bit [15:0] d);
    bus.regWE = 1'b1; bus.regAddr = a; bus.regWData = d;
    tick();
    bus.regWE = 1'b0;
  endtask

  task automatic ack();
    bus.turnOffIRQ = 1'b1;
    tick();
    bus.turnOffIRQ = 1'b0;
  endtask

  task automatic rd_check(bit [2:0] a, string name);
    bus.regAddr = a;
    #1;
    chk(name, 32'(bus.regRData), 32'(m_reg(a)));
  endtask

  task automatic pulse(bit [CH-1:0] r);
    req = r;
    tick();
    req = '0;
  endtask

  // Monitor: per-cycle output check plus scoreboard pop on every irq rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("irq", 32'(bus.irq), 32'(m_serving >= 0));
        chk("int_addr", bus.intAddr, (m_serving >= 0) ? m_addr : 32'h0);
        chk("int_data", 32'(bus.intData), (m_serving >= 0) ? 32'(m_serving) : 32'h0);
        if (bus.irq && !prev_irq) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected_irq: irq rose with chan %0d, no interrupt expected", bus.intData);
          end else begin
            e = sb_q.pop_front();
            chk("sb_cycle", 32'(cyc), 32'(e.cyc));
            chk("sb_chan", 32'(bus.intData), 32'(e.chan));
            chk("sb_addr", bus.intAddr, e.addr);
          end
        end
        prev_irq = bus.irq;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bit [2:0] a;
    model_reset();
    bus.regWE = 1'b0; bus.regAddr = 3'd0; bus.regWData = 16'h0; bus.turnOffIRQ = 1'b0;
    rst = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;

    // Reset register values
    for (int i = 0; i < 8; i++) begin
      rd_check(3'(i), "reset_reg");
      tick();
    end
    rd_check(3'd2, "reset_mode");
    chk("reset_mode_const", 32'(bus.regRData), 32'h00FF);

    // Basic edge
    wr(3'd0, 16'h1); wr(3'd1, 16'h08); wr(3'd4, 16'h0001); wr(3'd5, 16'h0000);
    pulse(8'h08);
    idle(3);
    chk("basic_addr", bus.intAddr, 32'h0001_000C);
    chk("basic_data", 32'(bus.intData), 32'd3);
    ack();
    rd_check(3'd3, "basic_pending");
    idle(2);
    rd_check(3'd6, "basic_status");

    // Priority
    wr(3'd1, 16'h00FF);
    pulse(8'h24);
    idle(3);
    chk("prio_first", 32'(bus.intData), 32'd2);
    ack();
    idle(4);
    chk("prio_second", 32'(bus.intData), 32'd5);
    ack();
    idle(3);

    // Level mode: reassert while held, then drop during holdoff
    wr(3'd2, 16'h0000); wr(3'd1, 16'h0001);
    req = 8'h01;
    idle(4);
    ack();
    idle(4);
    ack();
    req = 8'h00;
    idle(5);
    wr(3'd2, 16'h00FF);

    // Collisions: edge vs acknowledge, edge vs write-1-clear
    wr(3'd1, 16'h0002);
    pulse(8'h02);
    idle(3);
    req = 8'h02; bus.turnOffIRQ = 1'b1;
    tick();
    req = 8'h00; bus.turnOffIRQ = 1'b0;
    rd_check(3'd3, "coll_ack_pending");
    chk("coll_ack_bit1", 32'(bus.regRData[1]), 32'd1);
    idle(4);
    ack();
    idle(3);
    wr(3'd1, 16'h0000);
    req = 8'h02; bus.regWE = 1'b1; bus.regAddr = 3'd3; bus.regWData = 16'h0002;
    tick();
    req = 8'h00; bus.regWE = 1'b0;
    rd_check(3'd3, "coll_w1c_pending");
    chk("coll_w1c_bit1", 32'(bus.regRData[1]), 32'd1);
    wr(3'd3, 16'h0002);
    rd_check(3'd3, "w1c_cleared");

    // Masking and enable
    wr(3'd0, 16'h0); wr(3'd1, 16'h10);
    pulse(8'h10);
    idle(3);
    wr(3'd0, 16'h1);
    idle(2);
    wr(3'd1, 16'h0);
    idle(3);
    ack();
    idle(3);

    // Address wrap, then reset during ASSERT with an in-flight acknowledge
    wr(3'd1, 16'h04); wr(3'd4, 16'hFFFF); wr(3'd5, 16'hFFFC);
    pulse(8'h04);
    idle(3);
    chk("wrap_addr", bus.intAddr, 32'h0000_0004);
    rst = 1'b1; bus.turnOffIRQ = 1'b1;
    tick();
    rst = 1'b0; bus.turnOffIRQ = 1'b0;
    chk("rst_irq", 32'(bus.irq), 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd_check(3'(i), "rst_reg");
      tick();
    end

    // Randomised traffic
    wr(3'd0, 16'h1); wr(3'd1, 16'($urandom)); wr(3'd2, 16'($urandom));
    wr(3'd4, 16'($urandom)); wr(3'd5, 16'($urandom));
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 99);
      req = CH'($urandom & $urandom & $urandom);
      bus.turnOffIRQ = ((m_serving >= 0) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 15) == 0);
      if (r < 6) begin
        a = 3'($urandom);
        bus.regWE = 1'b1;
        bus.regAddr = a;
        bus.regWData = (a == 3'd0) ? 16'($urandom_range(0, 3) != 0) : 16'($urandom);
      end
      if (r == 99 && $urandom_range(0, 3) == 0) rst = 1'b1;
      tick();
      bus.regWE = 1'b0; rst = 1'b0; bus.turnOffIRQ = 1'b0;
      if (r >= 90 && r < 95) rd_check(3'($urandom), "rnd_read");
    end

    // Drain
    req = '0;
    for (int c = 0; c < 20; c++) begin
      if (m_serving >= 0) ack();
      else tick();
    end
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
